pc_control: RTL and testbench

// - Next-PC generator for the 16-bit single-cycle CPU fetch stage.
// - Computes PC+2 or the PC-relative branch target from branch enable, condition

---
 rtl/pc_control.sv | 84 ++++++++
 tb/tb_pc_control.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pc_control.sv
// Next-PC generator: PC+2 or PC-relative branch target, plus the architectural PC register.
// Latency: PC_out/taken are combinational (zero cycles); pc_q follows PC_out one edge later.
// Backpressure: pc_en=0 stalls the PC register (holds pc_q); the next-PC logic never stalls.
module pc_control (
    input  logic        clk,
    input  logic        rst,
    input  logic        B,
    input  logic [2:0]  C,
    input  logic [8:0]  I,
    input  logic [2:0]  F,
    input  logic [15:0] PC_in,
    input  logic        pc_en,
    output logic [15:0] PC_out,
    output logic        taken,
    output logic [15:0] pc_q
);

    typedef enum logic [2:0] {
        CC_NEQ    = 3'b000,
        CC_EQ     = 3'b001,
        CC_GT     = 3'b010,
        CC_LT     = 3'b011,
        CC_GTE    = 3'b100,
        CC_LTE    = 3'b101,
        CC_OVF    = 3'b110,
        CC_UNCOND = 3'b111
    } cond_t;

    logic        n_flag;
    logic        z_flag;
    logic        v_flag;
    logic        cond_met;
    logic [15:0] pc_plus2;
    logic [15:0] offset_words;
    logic [15:0] target;
    logic [15:0] pc_d;

    assign n_flag = F[2];
    assign z_flag = F[1];
    assign v_flag = F[0];

    // Decode all eight condition codes explicitly so no code leaves cond_met undefined.
    always_comb begin
        cond_met = 1'b0;
        case (cond_t'(C))
            CC_NEQ:    cond_met = ~z_flag;
            CC_EQ:     cond_met = z_flag;
            CC_GT:     cond_met = ~z_flag & ~n_flag;
            CC_LT:     cond_met = n_flag;
            CC_GTE:    cond_met = z_flag | (~z_flag & ~n_flag);
            CC_LTE:    cond_met = n_flag | z_flag;
            CC_OVF:    cond_met = v_flag;
            CC_UNCOND: cond_met = 1'b1;
            default:   cond_met = 1'b0;
        endcase
    end

    // Next-PC arithmetic; offset is in instruction words, so scale by two bytes. Wraps mod 2^16.
    always_comb begin
        pc_plus2     = PC_in + 16'd2;
        offset_words = {{7{I[8]}}, I};
        target       = pc_plus2 + (offset_words << 1);
        taken        = B & cond_met;
        PC_out       = taken ? target : pc_plus2;
    end

    // PC register next value: load the computed next PC, or hold while stalled.
    always_comb begin
        pc_d = pc_q;
        if (pc_en) begin
            pc_d = PC_out;
        end
    end

    // Architectural PC register; reset clears it immediately and overrides pc_en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= 16'h0000;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: tb/tb_pc_control.sv
// Testbench for pc_control: directed and swept next-PC vectors plus PC register sequencing.
// Expected values come from constants or a small reference model, queued on drive.
// Each queued expectation is popped and compared once the DUT outputs settle.
module tb_pc_control;

    logic        clk = 1'b0;
    logic        rst;
    logic        B;
    logic [2:0]  C;
    logic [8:0]  I;
    logic [2:0]  F;
    logic [15:0] pc_in_drv;
    logic [15:0] PC_in;
    logic        pc_en;
    logic [15:0] PC_out;
    logic        taken;
    logic [15:0] pc_q;
    logic        loop_mode;

    assign PC_in = loop_mode ? pc_q : pc_in_drv;

    always #5 clk = ~clk;

    pc_control dut (
        .clk    (clk),
        .rst    (rst),
        .B      (B),
        .C      (C),
        .I      (I),
        .F      (F),
        .PC_in  (PC_in),
        .pc_en  (pc_en),
        .PC_out (PC_out),
        .taken  (taken),
        .pc_q   (pc_q)
    );

    typedef struct {
        string       tag;
        bit          is_pcq;
        logic [15:0] pc;
        logic        tk;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Reference condition table, written directly from the flag definitions.
    function automatic logic ref_cond(input logic [2:0] c, input logic [2:0] f);
        logic n, z, v;
        n = f[2];
        z = f[1];
        v = f[0];
        case (c)
            3'd0:    return (z == 1'b0);
            3'd1:    return (z == 1'b1);
            3'd2:    return (z == 1'b0) && (n == 1'b0);
            3'd3:    return (n == 1'b1);
            3'd4:    return (z == 1'b1) || ((z == 1'b0) && (n == 1'b0));
            3'd5:    return (n == 1'b1) || (z == 1'b1);
            3'd6:    return (v == 1'b1);
            default: return 1'b1;
        endcase
    endfunction

    // Reference next PC using integer arithmetic, then truncated to 16 bits.
    function automatic logic [15:0] ref_next(input logic [15:0] pc, input logic [8:0] i, input logic tk);
        int off;
        int t;
        off = $signed(i);
        t   = int'(pc) + 2 + (tk ? 2 * off : 0);
        return t[15:0];
    endfunction

    task automatic sb_pop();
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL sb_underflow: got empty queue expected entry");
            return;
        end
        e = sb.pop_front();
        if (e.is_pcq) begin
            check_eq({e.tag, "_pcq"}, pc_q, e.pc);
        end else begin
            check_eq({e.tag, "_pc"}, PC_out, e.pc);
            check_eq({e.tag, "_tk"}, {15'b0, taken}, {15'b0, e.tk});
        end
    endtask

    task automatic drive_lit(input string tag, input logic b, input logic [2:0] c,
                             input logic [8:0] i, input logic [2:0] f, input logic [15:0] pc,
                             input logic exp_tk, input logic [15:0] exp_pc);
        B = b; C = c; I = i; F = f; pc_in_drv = pc;
        sb.push_back('{tag: tag, is_pcq: 1'b0, pc: exp_pc, tk: exp_tk});
        #1;
        sb_pop();
    endtask

    task automatic drive_model(input string tag, input logic b, input logic [2:0] c,
                               input logic [8:0] i, input logic [2:0] f, input logic [15:0] pc);
        logic tk;
        tk = b & ref_cond(c, f);
        drive_lit(tag, b, c, i, f, pc, tk, ref_next(pc, i, tk));
    endtask

    logic [15:0] exp_pc;

    initial begin
        rst = 1'b1; pc_en = 1'b0; loop_mode = 1'b0;
        B = 1'b0; C = 3'd0; I = 9'd0; F = 3'd0; pc_in_drv = 16'h0;
        #2;
        check_eq("reset_pcq", pc_q, 16'h0000);

        // Directed vectors with hand-computed results.
        drive_lit("uncond",    1'b1, 3'b111, 9'h001, 3'b000, 16'h0000, 1'b1, 16'h0004);
        drive_lit("eq_taken",  1'b1, 3'b001, 9'h002, 3'b010, 16'h0001, 1'b1, 16'h0007);
        drive_lit("neq_not",   1'b1, 3'b000, 9'h002, 3'b011, 16'h0002, 1'b0, 16'h0004);
        drive_lit("b0_uncond", 1'b0, 3'b111, 9'h001, 3'b000, 16'h0003, 1'b0, 16'h0005);
        drive_lit("neg_one",   1'b1, 3'b111, 9'h1FF, 3'b000, 16'h0010, 1'b1, 16'h0010);
        drive_lit("ovf_taken", 1'b1, 3'b110, 9'h1FF, 3'b001, 16'h0010, 1'b1, 16'h0010);
        drive_lit("ovf_not",   1'b1, 3'b110, 9'h1FF, 3'b110, 16'h0010, 1'b0, 16'h0012);
        drive_lit("wrap_p2",   1'b0, 3'b111, 9'h100, 3'b000, 16'hFFFE, 1'b0, 16'h0000);
        drive_lit("wrap_m256", 1'b1, 3'b111, 9'h100, 3'b000, 16'hFFFE, 1'b1, 16'hFE00);
        drive_lit("max_pos",   1'b1, 3'b111, 9'h0FF, 3'b000, 16'hFF00, 1'b1, 16'h0100);

        // Sweep every condition code against every flag combination, random offset/PC.
        for (int c = 0; c < 8; c++) begin
            for (int f = 0; f < 8; f++) begin
                drive_model("sweep_b1", 1'b1, 3'(c), 9'($urandom_range(0, 511)), 3'(f),
                            16'($urandom_range(0, 65535)));
                drive_model("sweep_b0", 1'b0, 3'(c), 9'($urandom_range(0, 511)), 3'(f),
                            16'($urandom_range(0, 65535)));
            end
        end

        // PC register loop: PC_in follows pc_q, no branches.
        @(negedge clk);
        rst = 1'b0; loop_mode = 1'b1; B = 1'b0; C = 3'd7; I = 9'd0; F = 3'd0; pc_en = 1'b1;
        exp_pc = 16'h0000;
        repeat (2) begin
            exp_pc = exp_pc + 16'd2;
            sb.push_back('{tag: "run", is_pcq: 1'b1, pc: exp_pc, tk: 1'b0});
            @(posedge clk); #1;
            sb_pop();
        end
        check_eq("loop_pc_out", PC_out, 16'h0006);

        @(negedge clk);
        pc_en = 1'b0;
        repeat (2) begin
            sb.push_back('{tag: "stall", is_pcq: 1'b1, pc: exp_pc, tk: 1'b0});
            @(posedge clk); #1;
            sb_pop();
        end

        @(negedge clk);
        pc_en = 1'b1;
        exp_pc = exp_pc + 16'd2;
        sb.push_back('{tag: "resume", is_pcq: 1'b1, pc: exp_pc, tk: 1'b0});
        @(posedge clk); #1;
        sb_pop();

        // Reset asserted between edges clears the register without waiting for a clock.
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("async_clear", pc_q, 16'h0000);
        @(posedge clk); #1;
        check_eq("rst_over_en", pc_q, 16'h0000);

        @(negedge clk);
        rst = 1'b0;
        sb.push_back('{tag: "after_rst", is_pcq: 1'b1, pc: 16'h0002, tk: 1'b0});
        @(posedge clk); #1;
        sb_pop();

        if (sb.size() != 0) begin
            n_checks++;
            $display("FAIL sb_leftover: got %0d entries expected 0", sb.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
